strm_fifo_v2: RTL
=================

Name: strm_fifo_v2

Overview:
Parameterised synchronous stream FIFO with valid/ready on both sides. It is the next generation of the team's stream FIFO and adds the following:
- non-power-of-2 depth support
- a fill-level output
- programmable almost-full and almost-empty flags
- a synchronous flush
- an optional drop-on-full mode with a saturating drop counter

It sits between stream producers and consumers in the comm-control datapath, on a single clock domain.

Parameters:
WIDTH, 16, data width in bits (>=1)
DEPTH, 8, number of entries (>=2, any integer, need not be a power of 2)
AF_THRESH, 6, almost_full asserts when level >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH (0..DEPTH-1)
DROP_ON_FULL, 0, 0 = backpressure when full; 1 = always ready, discard writes when full
DCNT_W, 8, drop counter width

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of FIFO contents
wr_valid  in  1  write valid
wr_ready  out  1  write ready
wr_data  in  WIDTH  write data
rd_valid  out  1  read valid
rd_ready  in  1  read ready
rd_data  out  WIDTH  read data (head entry)
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  $clog2(DEPTH+1)  current occupancy
drop_cnt  out  DCNT_W  count of discarded writes; saturates at all-ones
drop_clr  in  1  synchronous clear of drop_cnt

Behaviour:
Reset:
- One clock, clk; reset is asynchronous and active-high, port rst.
- While rst=1 and after release: wr_ptr=0, rd_ptr=0, level=0, drop_cnt=0.
- Resulting outputs: empty=1, full=0, rd_valid=0, almost_empty=1, almost_full=0, wr_ready=1.
- Storage array is not reset; rd_data is don't-care while rd_valid=0.

Handshakes:
- wr_ready = ~full when DROP_ON_FULL=0; constant 1 when DROP_ON_FULL=1.
- wr_xfer = wr_valid & wr_ready & ~full & ~flush.
- rd_valid = ~empty (combinational from the level register).
- rd_data = mem[rd_ptr], first-word-fall-through.
- rd_xfer = rd_valid & rd_ready & ~flush.

Latency:
- A word written in cycle N is visible on rd_valid/rd_data in cycle N+1.
- Empty-to-valid latency is therefore 1 cycle, with no bubble on back-to-back traffic.

Pointers:
- Each pointer is $clog2(DEPTH) bits and increments on its xfer.
- Each wraps from DEPTH-1 to 0 explicitly; no reliance on power-of-2 overflow.

Level:
- +1 on wr_xfer only.
- -1 on rd_xfer only.
- Unchanged when both occur or neither occurs.

Status flags:
- full, empty, almost_full and almost_empty are combinational decodes of the registered level.

Boundary conditions:
- Full with DROP_ON_FULL=0: wr_ready=0 and no write occurs. A simultaneous read frees a slot, but that slot is only usable from the next cycle (no combinational ready-from-read path).
- Full with DROP_ON_FULL=1: wr_valid=1 accepts the handshake but discards the data; drop_cnt increments by 1, saturating. A read in the same cycle does not rescue the write.
- Empty: rd_valid=0 and rd_ready is ignored. A concurrent write makes data valid next cycle.
- Simultaneous wr_xfer and rd_xfer at level k (0<k<DEPTH): level stays k and both pointers advance.

Flush:
- flush=1 sets wr_ptr, rd_ptr and level to 0 at the next edge.
- It has priority over any concurrent xfer in that cycle; a write in that cycle is lost and is not counted as a drop.
- drop_cnt is unaffected by flush.
- drop_clr=1 zeroes drop_cnt; it takes priority over a concurrent drop increment.

Reset mid-operation:
- Asserting rst clears all state asynchronously. Outputs take their reset values immediately, without waiting for a clock edge.

Decomposition:
Shared package fifo_pkg holds:
- function ptr_w(depth), returning max(1, $clog2(depth))
- function lvl_w(depth), returning $clog2(depth+1)
- enum drop_mode_e {BACKPRESSURE, DROP}, matching DROP_ON_FULL

Sub-module fifo_wrap_ptr (parameters DEPTH; ports clk, rst, clr, inc, ptr) is instantiated twice, once for the write pointer and once for the read pointer. The saturating drop counter stays inline.

Test Plan:
1. DEPTH=5, write 5 words 0x11..0x15 with no reads -> full=1 after the 5th edge, wr_ready=0, level=5, almost_full=1 from level 4 onward (AF_THRESH=4).
2. DEPTH=5, fill 5 then read 7 with writes interleaved -> output order 0x11..0x15 then new data; pointers wrap at 4->0; empty=1 only when level=0.
3. level=3, wr_xfer and rd_xfer together for 10 cycles -> level stays 3, data order preserved, no flag toggles.
4. DROP_ON_FULL=1, full, wr_valid=1 for 300 cycles with DCNT_W=8 -> FIFO contents unchanged, drop_cnt saturates at 255; drop_clr -> 0 next cycle.
5. level=4, flush=1 with wr_valid=1 and rd_ready=1 -> next cycle level=0, empty=1, rd_valid=0, drop_cnt unchanged.
6. rst pulsed mid-burst at level=2 -> outputs reset immediately (empty=1, rd_valid=0, level=0); the first write after release reads back correctly.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: width helpers and drop-mode encoding shared by the stream FIFO blocks
package fifo_pkg;

    typedef enum logic {BACKPRESSURE = 1'b0, DROP = 1'b1} drop_mode_e;

    function automatic int ptr_w(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: modulo-DEPTH pointer with explicit wrap so any depth works
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    inc,
    output logic [ptr_w(DEPTH)-1:0] ptr
);
    localparam int PW = ptr_w(DEPTH);

    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= '0;
        else if (clr) ptr <= '0;
        else if (inc) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);

endmodule

// File: rtl/strm_fifo_v2.sv
// strm_fifo_v2: valid/ready stream FIFO with fill level, almost flags, flush and drop-on-full
module strm_fifo_v2
    import fifo_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 8,
    parameter int AF_THRESH    = 6,
    parameter int AE_THRESH    = 2,
    parameter int DROP_ON_FULL = 0,
    parameter int DCNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [WIDTH-1:0]        wr_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [lvl_w(DEPTH)-1:0] level,
    output logic [DCNT_W-1:0]       drop_cnt,
    input  logic                    drop_clr
);
    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    localparam drop_mode_e MODE = (DROP_ON_FULL != 0) ? DROP : BACKPRESSURE;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             wr_xfer, rd_xfer, drop;

    assign full         = level == LW'(DEPTH);
    assign empty        = level == '0;
    assign almost_full  = level >= LW'(AF_THRESH);
    assign almost_empty = level <= LW'(AE_THRESH);
    assign wr_ready     = (MODE == DROP) || !full;
    assign rd_valid     = !empty;
    assign rd_data      = mem[rd_ptr];
    assign wr_xfer      = wr_valid && wr_ready && !full && !flush;
    assign rd_xfer      = rd_valid && rd_ready && !flush;
    // a write lost to flush is not a drop
    assign drop         = (MODE == DROP) && wr_valid && full && !flush;

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk(clk), .rst(rst), .clr(flush), .inc(wr_xfer), .ptr(wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk(clk), .rst(rst), .clr(flush), .inc(rd_xfer), .ptr(rd_ptr)
    );

    always_ff @(posedge clk)
        if (wr_xfer) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) level <= '0;
        else if (flush) level <= '0;
        else if (wr_xfer != rd_xfer) level <= wr_xfer ? level + LW'(1) : level - LW'(1);

    always_ff @(posedge clk or posedge rst)
        if (rst) drop_cnt <= '0;
        else if (drop_clr) drop_cnt <= '0;
        else if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DCNT_W'(1);

endmodule
